// File: rtl/pdp8_cycle_sequencer_if.sv
// Memory request bus between the PDP-8 cycle sequencer and the memory port.
// The sequencer (master) issues requests; the memory (slave) returns the ack.
interface pdp8_cycle_sequencer_if;
    logic       mem_req;
    logic       mem_we;
    logic [1:0] ma_sel;
    logic [1:0] wd_sel;
    logic       mem_ack;

    modport master (
        output mem_req,
        output mem_we,
        output ma_sel,
        output wd_sel,
        input  mem_ack
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  ma_sel,
        input  wd_sel,
        output mem_ack
    );
endinterface

// File: rtl/pdp8_cycle_sequencer.sv
// PDP-8 major-state controller: sequences each instruction through the Fetch,
// Defer and Execute memory cycles and drives the datapath strobes.
// Optional build macro PDP8_AUTOINDEX_EN: when defined, auto-index pointers
// (PPIND) are incremented and written back before the effective address is
// used; when undefined, PPIND behaves exactly like IND.
module pdp8_cycle_sequencer (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           run,
    input  logic                           aand,
    input  logic                           tad,
    input  logic                           isz,
    input  logic                           dca,
    input  logic                           jms,
    input  logic                           jmp,
    input  logic                           iot,
    input  logic                           opr,
    input  logic                           ind,
    input  logic                           ppind,
    input  logic                           md_zero,
    pdp8_cycle_sequencer_if.master         mem,
    output logic                           ld_ir,
    output logic                           ld_md,
    output logic                           inc_md,
    output logic                           inc_pc,
    output logic                           ld_pc,
    output logic                           clr_ac,
    output logic                           exec_stb,
    output logic                           instr_done,
    output logic [3:0]                     state
);

    typedef enum logic [3:0] {
        ST_HALT    = 4'd0,
        ST_FETCH   = 4'd1,
        ST_DECODE  = 4'd2,
        ST_DEFER   = 4'd3,
        ST_AUTOINC = 4'd4,
        ST_AUTOWR  = 4'd5,
        ST_OPRD    = 4'd6,
        ST_EXEC    = 4'd7,
        ST_ISZINC  = 4'd8,
        ST_ISZWR   = 4'd9,
        ST_DCAWR   = 4'd10,
        ST_JMSWR   = 4'd11,
        ST_JUMP    = 4'd12,
        ST_JMSINC  = 4'd13,
        ST_END     = 4'd14
    } state_t;

    state_t state_r;
    state_t state_nxt_s;
    logic   ind_r;
    logic   ack_s;

    // Route a memory-reference instruction to its first execute-phase state.
    // An op class with no memory operand finishes the instruction.
    function automatic state_t dispatch(input logic j_mp, input logic j_ms,
                                        input logic d_ca, input logic operand);
        state_t nxt;
        if (j_mp) begin
            nxt = ST_JUMP;
        end else if (j_ms) begin
            nxt = ST_JMSWR;
        end else if (d_ca) begin
            nxt = ST_DCAWR;
        end else if (operand) begin
            nxt = ST_OPRD;
        end else begin
            nxt = ST_END;
        end
        return nxt;
    endfunction

    // Effective-address source: the pointer loaded into MD when indirect,
    // otherwise the page/offset field of IR.
    function automatic logic [1:0] ea_sel(input logic indirect);
        return indirect ? 2'd2 : 2'd1;
    endfunction

    assign ack_s = mem.mem_ack;
    assign state = state_r;

    // State register and the indirect flag captured in DECODE.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_HALT;
            ind_r   <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            if (state_r == ST_DECODE) begin
                ind_r <= ind | ppind;
            end else begin
                ind_r <= ind_r;
            end
        end
    end

    // Next-state logic and state-decoded outputs (ack-qualified where noted).
    always_comb begin
        state_nxt_s  = state_r;
        mem.mem_req  = 1'b0;
        mem.mem_we   = 1'b0;
        mem.ma_sel   = 2'd0;
        mem.wd_sel   = 2'd0;
        ld_ir        = 1'b0;
        ld_md        = 1'b0;
        inc_md       = 1'b0;
        inc_pc       = 1'b0;
        ld_pc        = 1'b0;
        clr_ac       = 1'b0;
        exec_stb     = 1'b0;
        instr_done   = 1'b0;
        case (state_r)
            ST_HALT: begin
                state_nxt_s = run ? ST_FETCH : ST_HALT;
            end
            ST_FETCH: begin
                mem.mem_req = 1'b1;
                ld_ir       = ack_s;
                inc_pc      = ack_s;
                state_nxt_s = ack_s ? ST_DECODE : ST_FETCH;
            end
            ST_DECODE: begin
                if (iot | opr) begin
                    state_nxt_s = ST_EXEC;
                end else if (ind | ppind) begin
                    state_nxt_s = ST_DEFER;
                end else begin
                    state_nxt_s = dispatch(jmp, jms, dca, aand | tad | isz);
                end
            end
            ST_DEFER: begin
                mem.mem_req = 1'b1;
                mem.ma_sel  = 2'd1;
                ld_md       = ack_s;
                if (!ack_s) begin
                    state_nxt_s = ST_DEFER;
`ifdef PDP8_AUTOINDEX_EN
                end else if (ppind) begin
                    state_nxt_s = ST_AUTOINC;
`endif
                end else begin
                    state_nxt_s = dispatch(jmp, jms, dca, aand | tad | isz);
                end
            end
`ifdef PDP8_AUTOINDEX_EN
            ST_AUTOINC: begin
                inc_md      = 1'b1;
                state_nxt_s = ST_AUTOWR;
            end
            ST_AUTOWR: begin
                mem.mem_req = 1'b1;
                mem.mem_we  = 1'b1;
                mem.ma_sel  = 2'd1;
                mem.wd_sel  = 2'd0;
                if (ack_s) begin
                    state_nxt_s = dispatch(jmp, jms, dca, aand | tad | isz);
                end else begin
                    state_nxt_s = ST_AUTOWR;
                end
            end
`endif
            ST_OPRD: begin
                mem.mem_req = 1'b1;
                mem.ma_sel  = ea_sel(ind_r);
                ld_md       = ack_s;
                if (!ack_s) begin
                    state_nxt_s = ST_OPRD;
                end else if (isz) begin
                    state_nxt_s = ST_ISZINC;
                end else begin
                    state_nxt_s = ST_EXEC;
                end
            end
            ST_EXEC: begin
                exec_stb    = 1'b1;
                state_nxt_s = ST_END;
            end
            ST_ISZINC: begin
                inc_md      = 1'b1;
                state_nxt_s = ST_ISZWR;
            end
            ST_ISZWR: begin
                mem.mem_req = 1'b1;
                mem.mem_we  = 1'b1;
                mem.ma_sel  = ea_sel(ind_r);
                mem.wd_sel  = 2'd0;
                inc_pc      = ack_s & md_zero;
                state_nxt_s = ack_s ? ST_END : ST_ISZWR;
            end
            ST_DCAWR: begin
                mem.mem_req = 1'b1;
                mem.mem_we  = 1'b1;
                mem.ma_sel  = ea_sel(ind_r);
                mem.wd_sel  = 2'd1;
                clr_ac      = ack_s;
                state_nxt_s = ack_s ? ST_END : ST_DCAWR;
            end
            ST_JMSWR: begin
                mem.mem_req = 1'b1;
                mem.mem_we  = 1'b1;
                mem.ma_sel  = ea_sel(ind_r);
                mem.wd_sel  = 2'd2;
                ld_pc       = ack_s;
                state_nxt_s = ack_s ? ST_JMSINC : ST_JMSWR;
            end
            ST_JUMP: begin
                mem.ma_sel  = ea_sel(ind_r);
                ld_pc       = 1'b1;
                state_nxt_s = ST_END;
            end
            ST_JMSINC: begin
                inc_pc      = 1'b1;
                state_nxt_s = ST_END;
            end
            ST_END: begin
                instr_done  = 1'b1;
                state_nxt_s = run ? ST_FETCH : ST_HALT;
            end
            default: begin
                state_nxt_s = ST_HALT;
            end
        endcase
    end

endmodule

// File: tb/tb_pdp8_cycle_sequencer.sv
// Self-checking bench for pdp8_cycle_sequencer. A per-instruction reference
// model expands each instruction into its expected list of major cycles and
// every clock cycle is compared against it, with random memory ack delays.
module tb_pdp8_cycle_sequencer;

`ifdef PDP8_AUTOINDEX_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    localparam int OP_AND = 0, OP_TAD = 1, OP_ISZ = 2, OP_DCA = 3;
    localparam int OP_JMS = 4, OP_JMP = 5, OP_IOT = 6, OP_OPR = 7;

    // Strobe bit positions: ld_ir ld_md inc_md inc_pc ld_pc clr_ac exec done
    localparam logic [7:0] S_LDIR  = 8'h80;
    localparam logic [7:0] S_LDMD  = 8'h40;
    localparam logic [7:0] S_INCMD = 8'h20;
    localparam logic [7:0] S_INCPC = 8'h10;
    localparam logic [7:0] S_LDPC  = 8'h08;
    localparam logic [7:0] S_CLRAC = 8'h04;
    localparam logic [7:0] S_EXEC  = 8'h02;
    localparam logic [7:0] S_DONE  = 8'h01;

    typedef struct packed {
        logic [3:0] st;
        logic       mem;
        logic       we;
        logic [1:0] ma;
        logic [1:0] wd;
        logic [7:0] stb;
    } step_t;

    logic clk = 1'b0;
    logic reset, run;
    logic aand, tad, isz, dca, jms, jmp, iot, opr, ind, ppind, md_zero;
    logic ld_ir, ld_md, inc_md, inc_pc, ld_pc, clr_ac, exec_stb, instr_done;
    logic [3:0] state;

    int passed = 0;
    int total  = 0;
    step_t q[$];

    pdp8_cycle_sequencer_if bus ();

    pdp8_cycle_sequencer dut (
        .clk(clk), .reset(reset), .run(run),
        .aand(aand), .tad(tad), .isz(isz), .dca(dca),
        .jms(jms), .jmp(jmp), .iot(iot), .opr(opr),
        .ind(ind), .ppind(ppind), .md_zero(md_zero),
        .mem(bus.master),
        .ld_ir(ld_ir), .ld_md(ld_md), .inc_md(inc_md), .inc_pc(inc_pc),
        .ld_pc(ld_pc), .clr_ac(clr_ac), .exec_stb(exec_stb),
        .instr_done(instr_done), .state(state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [17:0] exp);
        logic [17:0] obs;
        obs = {state, bus.mem_req, bus.mem_we, bus.ma_sel, bus.wd_sel,
               ld_ir, ld_md, inc_md, inc_pc, ld_pc, clr_ac, exec_stb, instr_done};
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h (st/req/we/ma/wd/stb)", tag, obs, exp);
    endtask

    task automatic push(input logic [3:0] st, input logic m, input logic w,
                        input logic [1:0] ma, input logic [1:0] wd, input logic [7:0] stb);
        step_t s;
        s.st = st; s.mem = m; s.we = w; s.ma = ma; s.wd = wd; s.stb = stb;
        q.push_back(s);
    endtask

    // Expected major-cycle list of one instruction, Fetch through End.
    task automatic build(input int op, input bit ind_i, input bit pp_i, input bit mdz);
        bit indir;
        logic [1:0] ea;
        q.delete();
        indir = ind_i | pp_i;
        ea = indir ? 2'd2 : 2'd1;
        push(4'd1, 1'b1, 1'b0, 2'd0, 2'd0, S_LDIR | S_INCPC);
        push(4'd2, 1'b0, 1'b0, 2'd0, 2'd0, 8'h00);
        if (op == OP_IOT || op == OP_OPR) begin
            push(4'd7, 1'b0, 1'b0, 2'd0, 2'd0, S_EXEC);
        end else begin
            if (indir) begin
                push(4'd3, 1'b1, 1'b0, 2'd1, 2'd0, S_LDMD);
                if (AUTO && pp_i) begin
                    push(4'd4, 1'b0, 1'b0, 2'd0, 2'd0, S_INCMD);
                    push(4'd5, 1'b1, 1'b1, 2'd1, 2'd0, 8'h00);
                end
            end
            if (op == OP_JMP) begin
                push(4'd12, 1'b0, 1'b0, ea, 2'd0, S_LDPC);
            end else if (op == OP_JMS) begin
                push(4'd11, 1'b1, 1'b1, ea, 2'd2, S_LDPC);
                push(4'd13, 1'b0, 1'b0, 2'd0, 2'd0, S_INCPC);
            end else if (op == OP_DCA) begin
                push(4'd10, 1'b1, 1'b1, ea, 2'd1, S_CLRAC);
            end else begin
                push(4'd6, 1'b1, 1'b0, ea, 2'd0, S_LDMD);
                if (op == OP_ISZ) begin
                    push(4'd8, 1'b0, 1'b0, 2'd0, 2'd0, S_INCMD);
                    push(4'd9, 1'b1, 1'b1, ea, 2'd0, mdz ? S_INCPC : 8'h00);
                end else begin
                    push(4'd7, 1'b0, 1'b0, 2'd0, 2'd0, S_EXEC);
                end
            end
        end
        push(4'd14, 1'b0, 1'b0, 2'd0, 2'd0, S_DONE);
    endtask

    // Drive one instruction cycle by cycle (DUT must be entering FETCH).
    task automatic run_instr(input string tag, input int op, input bit ind_i,
                             input bit pp_i, input bit mdz, input int mind,
                             input int maxd, input bit drop_run);
        int d;
        step_t s;
        aand = (op == OP_AND); tad = (op == OP_TAD); isz = (op == OP_ISZ);
        dca = (op == OP_DCA); jms = (op == OP_JMS); jmp = (op == OP_JMP);
        iot = (op == OP_IOT); opr = (op == OP_OPR);
        ind = ind_i; ppind = pp_i; md_zero = mdz;
        build(op, ind_i, pp_i, mdz);
        foreach (q[i]) begin
            s = q[i];
            d = s.mem ? int'($urandom_range(mind, maxd)) : 0;
            for (int k = 0; k <= d; k++) begin
                @(negedge clk);
                bus.mem_ack = s.mem && (k == d);
                if (drop_run && s.st == 4'd10) run = 1'b0;
                #1;
                check($sformatf("%s_c%0d_%0d", tag, i, k),
                      {s.st, s.mem, s.we, s.ma, s.wd, (bus.mem_ack || !s.mem) ? s.stb : 8'h00});
            end
        end
        @(negedge clk);
        bus.mem_ack = 1'b0;
    endtask

    // Idle cycles in HALT; run is raised at the last one if requested.
    task automatic halt_check(input string tag, input int n, input bit run_after);
        for (int i = 0; i < n; i++) begin
            if (i > 0) @(negedge clk);
            bus.mem_ack = 1'b0;
            if (i == n - 1) run = run_after;
            #1;
            check($sformatf("%s_%0d", tag, i), 18'h0);
        end
    endtask

    initial begin
        reset = 1'b1; run = 1'b1; bus.mem_ack = 1'b0;
        aand = 1'b0; tad = 1'b1; isz = 1'b0; dca = 1'b0; jms = 1'b0;
        jmp = 1'b0; iot = 1'b0; opr = 1'b0; ind = 1'b0; ppind = 1'b0; md_zero = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        halt_check("reset_state", 1, 1'b1);
        // FETCH pending, then reset for two edges
        @(negedge clk);
        #1;
        check("fetch_pending", {4'd1, 1'b1, 1'b0, 2'd0, 2'd0, 8'h00});
        reset = 1'b1;
        @(negedge clk);
        #1;
        check("reset_mid_fetch", 18'h0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("reset_release", 18'h0);
        @(negedge clk);
        bus.mem_ack = 1'b0;

        // After the release cycle, FETCH is re-entered.
        run_instr("tad_dir", OP_TAD, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
        run_instr("isz_skip", OP_ISZ, 1'b0, 1'b0, 1'b1, 2, 2, 1'b0);
        run_instr("isz_noskip", OP_ISZ, 1'b0, 1'b0, 1'b0, 2, 2, 1'b0);
        run_instr("jms_ind", OP_JMS, 1'b1, 1'b0, 1'b0, 0, 1, 1'b0);
        run_instr("jmp_dir", OP_JMP, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
        run_instr("tad_pp", OP_TAD, 1'b0, 1'b1, 1'b0, 0, 0, 1'b0);
        run_instr("tad_ind", OP_TAD, 1'b1, 1'b0, 1'b0, 0, 0, 1'b0);
        run_instr("opr_ind", OP_OPR, 1'b1, 1'b0, 1'b0, 0, 1, 1'b0);
        run_instr("dca_drop", OP_DCA, 1'b0, 1'b0, 1'b0, 1, 2, 1'b1);
        // Back from the negedge of END: stays in HALT with no request.
        halt_check_after_drop();

        for (int n = 0; n < 30; n++) begin
            run_instr($sformatf("rnd%0d", n), int'($urandom_range(0, 7)),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), 0, 3, 1'b0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    // run_instr leaves us at the negedge after END, i.e. the first HALT cycle.
    task automatic halt_check_after_drop();
        halt_check("halt_after_drop", 3, 1'b1);
        @(negedge clk);
    endtask

endmodule
